// File: rtl/md4_crack_sched.sv
// Candidate sequencer for the brute-force NT-hash datapath: enumerates passwords
// in length-then-odometer order and drives the md4calc / hashchecker handshakes.
module md4_crack_sched #(
    parameter logic [7:0]  CHAR_FIRST = 8'h61,
    parameter logic [7:0]  CHAR_LAST  = 8'h7a,
    parameter int unsigned MAX_LEN    = 8,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    output logic [159:0] passwd_chars,
    output logic [7:0]   passwd_len,
    output logic         md4_irdy,
    input  logic         md4_ordy,
    output logic         checker_checkrdy,
    input  logic         checker_resultrdy,
    input  logic         checker_matchfound,
    output logic         busy,
    output logic         is_done,
    output logic         match_found,
    output logic         timed_out,
    output logic [31:0]  cand_count
);

    localparam int unsigned NCHAR = 20;
    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [NCHAR-1:0][7:0] FIRST_CAND = {CHAR_FIRST, {(8 * (NCHAR - 1)){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_MD4_GO,
        S_MD4_WAIT,
        S_CHK_GO,
        S_CHK_WAIT,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [NCHAR-1:0][7:0]   r_chars;
    logic [7:0]              r_len;
    logic                    r_md4_irdy;
    logic                    r_chk;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_match;
    logic                    r_tmo;
    logic [31:0]             r_cnt;
    logic [CNT_W-1:0]        r_wait;

    logic [NCHAR-1:0][7:0]   w_next_chars;
    logic [7:0]              w_next_len;
    logic                    w_exhausted;
    logic                    w_in_busy;

    // Packed element NCHAR-1 is char 0, so the packed array maps straight onto the output bus.
    assign passwd_chars     = r_chars;
    assign passwd_len       = r_len;
    assign md4_irdy         = r_md4_irdy;
    assign checker_checkrdy = r_chk;
    assign busy             = r_busy;
    assign is_done          = r_done;
    assign match_found      = r_match;
    assign timed_out        = r_tmo;
    assign cand_count       = r_cnt;

    assign w_in_busy = (r_state != S_IDLE) && (r_state != S_DONE);

    // Odometer step: last active char is least significant; carry out of char 0 grows the length.
    always_comb begin
        logic carry;
        carry        = 1'b1;
        w_next_chars = r_chars;
        w_next_len   = r_len;
        w_exhausted  = 1'b0;
        for (int j = 0; j < int'(NCHAR); j++) begin
            if (carry && (j >= int'(NCHAR) - int'(r_len))) begin
                if (r_chars[5'(j)] == CHAR_LAST) begin
                    w_next_chars[5'(j)] = CHAR_FIRST;
                end else begin
                    w_next_chars[5'(j)] = r_chars[5'(j)] + 8'd1;
                    carry = 1'b0;
                end
            end
        end
        if (carry) begin
            if (r_len >= 8'(MAX_LEN)) begin
                w_exhausted = 1'b1;
            end else begin
                w_next_len = r_len + 8'd1;
                for (int j = 0; j < int'(NCHAR); j++) begin
                    if (j == int'(NCHAR) - 1 - int'(r_len)) begin
                        w_next_chars[5'(j)] = CHAR_FIRST;
                    end
                end
            end
        end
    end

    // Sequencer FSM with registered handshake pulses and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_chars    <= '0;
            r_len      <= '0;
            r_md4_irdy <= 1'b0;
            r_chk      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_match    <= 1'b0;
            r_tmo      <= 1'b0;
            r_cnt      <= '0;
            r_wait     <= '0;
        end else begin
            r_md4_irdy <= 1'b0;
            r_chk      <= 1'b0;
            if (abort && w_in_busy) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start && !abort) begin
                            r_chars <= FIRST_CAND;
                            r_len   <= 8'd1;
                            r_done  <= 1'b0;
                            r_match <= 1'b0;
                            r_tmo   <= 1'b0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        r_md4_irdy <= 1'b1;
                        r_state    <= S_MD4_GO;
                    end
                    S_MD4_GO: begin
                        r_wait  <= '0;
                        r_state <= S_MD4_WAIT;
                    end
                    S_MD4_WAIT: begin
                        if (md4_ordy) begin
                            r_chk   <= 1'b1;
                            r_state <= S_CHK_GO;
                        end else if (r_wait == TMO_LIMIT) begin
                            r_tmo   <= 1'b1;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_wait <= r_wait + CNT_W'(1);
                        end
                    end
                    S_CHK_GO: begin
                        r_wait  <= '0;
                        r_state <= S_CHK_WAIT;
                    end
                    S_CHK_WAIT: begin
                        if (checker_resultrdy) begin
                            r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + 32'd1;
                            if (checker_matchfound) begin
                                r_match <= 1'b1;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_ADVANCE;
                            end
                        end else if (r_wait == TMO_LIMIT) begin
                            r_tmo   <= 1'b1;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_wait <= r_wait + CNT_W'(1);
                        end
                    end
                    S_ADVANCE: begin
                        if (w_exhausted) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_chars <= w_next_chars;
                            r_len   <= w_next_len;
                            r_state <= S_SETUP;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_md4_crack_sched.sv
// Scoreboard bench for md4_crack_sched: two parameterisations, randomized handshake models.
module tb_md4_crack_sched;

    localparam logic [7:0] AF   = 8'h61;
    localparam logic [7:0] AL   = 8'h63;
    localparam int         NA   = 3;
    localparam int         AMAX = 2;
    localparam int         ATMO = 15;
    localparam logic [7:0] BF   = 8'h66;
    localparam int         BMAX = 3;

    typedef struct {
        logic [159:0] chars;
        logic [7:0]   len;
    } cand_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst_n, start_a, abort_a, start_b;
    logic [159:0] pc_a, pc_b;
    logic [7:0]   pl_a, pl_b;
    logic         irdy_a, ordy_a, chk_a, rr_a, mf_a, rr_m, mf_m, rr_f, mf_f;
    logic         busy_a, done_a, match_a, tmo_a;
    logic [31:0]  cnt_a, cnt_b;
    logic         irdy_b, ordy_b, chk_b, rr_b, busy_b, done_b, match_b, tmo_b;

    assign rr_a = rr_m | rr_f;
    assign mf_a = mf_m | mf_f;

    md4_crack_sched #(.CHAR_FIRST(AF), .CHAR_LAST(AL), .MAX_LEN(AMAX), .TIMEOUT(ATMO)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .passwd_chars(pc_a), .passwd_len(pl_a), .md4_irdy(irdy_a), .md4_ordy(ordy_a),
        .checker_checkrdy(chk_a), .checker_resultrdy(rr_a), .checker_matchfound(mf_a),
        .busy(busy_a), .is_done(done_a), .match_found(match_a), .timed_out(tmo_a),
        .cand_count(cnt_a)
    );

    md4_crack_sched #(.CHAR_FIRST(BF), .CHAR_LAST(BF), .MAX_LEN(BMAX), .TIMEOUT(ATMO)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0),
        .passwd_chars(pc_b), .passwd_len(pl_b), .md4_irdy(irdy_b), .md4_ordy(ordy_b),
        .checker_checkrdy(chk_b), .checker_resultrdy(rr_b), .checker_matchfound(1'b0),
        .busy(busy_b), .is_done(done_b), .match_found(match_b), .timed_out(tmo_b),
        .cand_count(cnt_b)
    );

    int    checks = 0;
    int    errors = 0;
    cand_t exp_a[$];
    cand_t exp_b[$];

    bit           md4_silent = 1'b0;
    bit           chk_silent = 1'b0;
    bit           target_en  = 1'b0;
    logic [159:0] target     = '0;
    int           exp_irdy_cyc = 0;
    int           exp_chk_cyc  = 0;
    int           last_irdy_cyc = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Candidate with value v written in base n over len chars, most significant char first.
    function automatic cand_t cand_of(input logic [7:0] first, input int n, input int len, input int v);
        cand_t c;
        int    x;
        c.chars = '0;
        c.len   = 8'(len);
        x       = v;
        for (int i = len - 1; i >= 0; i--) begin
            c.chars = c.chars | (160'(first + 8'(x % n)) << (8 * (19 - i)));
            x = x / n;
        end
        return c;
    endfunction

    function automatic int pow_int(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    function automatic int total_a();
        int t = 0;
        for (int l = 1; l <= AMAX; l++) t += pow_int(NA, l);
        return t;
    endfunction

    // k-th candidate of the a..c search, counting from 0.
    function automatic cand_t cand_a(input int k);
        int r = k;
        for (int l = 1; l <= AMAX; l++) begin
            if (r < pow_int(NA, l)) return cand_of(AF, NA, l, r);
            r -= pow_int(NA, l);
        end
        return cand_of(AF, NA, 1, 0);
    endfunction

    task automatic push_upto_a(input int last);
        for (int k = 0; k <= last; k++) exp_a.push_back(cand_a(k));
    endtask

    task automatic start_run_a();
        @(negedge clk);
        start_a = 1'b1;
        exp_irdy_cyc = cyc + 2;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string name);
        int n = 0;
        while (!done_a && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done_a) begin
            errors++;
            $display("FAIL %s_wait: is_done=%0b after %0d cycles, required 1", name, done_a, n);
        end
    endtask

    task automatic wait_irdy_a();
        int n = 0;
        while (!irdy_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("irdy_wait", 160'(irdy_a), 160'(1));
    endtask

    task automatic wait_chk_a();
        int n = 0;
        while (!chk_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("checkrdy_wait", 160'(chk_a), 160'(1));
    endtask

    // md4calc model: raises ordy 1..5 cycles after the start pulse, holds it 1..3 cycles.
    initial begin
        ordy_a = 1'b0;
        forever begin
            @(negedge clk);
            if (irdy_a && !md4_silent) begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
                ordy_a = 1'b1;
                exp_chk_cyc = cyc + 1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                ordy_a = 1'b0;
            end
        end
    end

    // hashchecker model: verdict 1..5 cycles after the check pulse, held 1..3 cycles.
    initial begin
        rr_m = 1'b0;
        mf_m = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_a && !chk_silent) begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
                rr_m = 1'b1;
                mf_m = target_en && (pc_a == target);
                exp_irdy_cyc = cyc + 3;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rr_m = 1'b0;
                mf_m = 1'b0;
            end
        end
    end

    // Instant models for the single-char instance: ready one cycle after each pulse.
    initial begin
        logic irdy_d, chk_d;
        irdy_d = 1'b0;
        chk_d  = 1'b0;
        ordy_b = 1'b0;
        rr_b   = 1'b0;
        forever begin
            @(negedge clk);
            ordy_b = irdy_d;
            rr_b   = chk_d;
            irdy_d = irdy_b;
            chk_d  = chk_b;
        end
    end

    // Monitor for instance A: every md4 start pulse must carry the next expected candidate.
    initial begin
        cand_t e;
        logic  prev_irdy;
        prev_irdy = 1'b0;
        forever begin
            @(negedge clk);
            if (irdy_a) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL irdy_unexpected: md4_irdy=1 with cand %0h len %0d, required no pulse", pc_a, pl_a);
                end else begin
                    e = exp_a.pop_front();
                    chk("cand_chars", pc_a, e.chars);
                    chk("cand_len", 160'(pl_a), 160'(e.len));
                end
                chk("irdy_latency", 160'(cyc), 160'(exp_irdy_cyc));
                chk("irdy_pulse", 160'(prev_irdy), 160'(0));
                last_irdy_cyc = cyc;
            end
            if (chk_a) chk("checkrdy_latency", 160'(cyc), 160'(exp_chk_cyc));
            prev_irdy = irdy_a;
        end
    end

    // Monitor for instance B.
    initial begin
        cand_t e;
        forever begin
            @(negedge clk);
            if (irdy_b) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL irdy_b_unexpected: cand %0h len %0d, required no pulse", pc_b, pl_b);
                end else begin
                    e = exp_b.pop_front();
                    chk("b_cand_chars", pc_b, e.chars);
                    chk("b_cand_len", 160'(pl_b), 160'(e.len));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int t;
        int n;
        rst_n   = 1'b0;
        start_a = 1'b0;
        abort_a = 1'b0;
        start_b = 1'b0;
        rr_f    = 1'b0;
        mf_f    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_a_flags", 160'({busy_a, done_a, match_a, tmo_a, irdy_a, chk_a, cnt_a, pl_a}), 160'(0));
        chk("reset_a_chars", pc_a, 160'(0));
        chk("reset_b_flags", 160'({busy_b, done_b, match_b, tmo_b, irdy_b, chk_b, cnt_b, pl_b}), 160'(0));
        rst_n = 1'b1;

        // Single-char charset: f, ff, fff then exhaustion.
        for (int l = 1; l <= BMAX; l++) exp_b.push_back(cand_of(BF, 1, l, 0));
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("b_done", 160'(done_b), 160'(1));
        chk("b_count", 160'(cnt_b), 160'(BMAX));
        chk("b_flags", 160'({busy_b, match_b, tmo_b}), 160'(0));
        chk("b_queue_left", 160'(exp_b.size()), 160'(0));

        // Full exhaustion of a..c up to length 2.
        target_en = 1'b0;
        push_upto_a(total_a() - 1);
        start_run_a();
        wait_done_a("exhaust");
        chk("exhaust_count", 160'(cnt_a), 160'(total_a()));
        chk("exhaust_flags", 160'({busy_a, match_a, tmo_a}), 160'(0));
        chk("exhaust_queue_left", 160'(exp_a.size()), 160'(0));

        // Match on "ab", then no further pulses.
        target    = cand_a(4).chars;
        target_en = 1'b1;
        push_upto_a(4);
        start_run_a();
        wait_done_a("match_ab");
        repeat (10) @(negedge clk);
        chk("ab_match", 160'(match_a), 160'(1));
        chk("ab_prefix", 160'(pc_a[159:144]), 160'(16'h6162));
        chk("ab_len", 160'(pl_a), 160'(2));
        chk("ab_count", 160'(cnt_a), 160'(5));
        chk("ab_queue_left", 160'(exp_a.size()), 160'(0));

        // Random targets, with a stray start while busy.
        for (int r = 0; r < 6; r++) begin
            t = $urandom_range(0, total_a() - 1);
            target    = cand_a(t).chars;
            target_en = 1'b1;
            push_upto_a(t);
            start_run_a();
            if (t >= 1) begin
                repeat (4) @(negedge clk);
                start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
            end
            wait_done_a("rand_match");
            chk("rand_match_flag", 160'({match_a, tmo_a, busy_a}), 160'(3'b100));
            chk("rand_match_count", 160'(cnt_a), 160'(t + 1));
            chk("rand_match_cand", pc_a, cand_a(t).chars);
            chk("rand_queue_left", 160'(exp_a.size()), 160'(0));
        end
        target_en = 1'b0;

        // md4calc never answers: timeout 16 cycles after entering the wait state.
        md4_silent = 1'b1;
        push_upto_a(0);
        start_run_a();
        wait_done_a("md4_timeout");
        chk("md4_timeout_cycle", 160'(cyc), 160'(last_irdy_cyc + 17));
        chk("md4_timeout_flags", 160'({tmo_a, match_a, busy_a}), 160'(3'b100));
        chk("md4_timeout_count", 160'(cnt_a), 160'(0));
        md4_silent = 1'b0;
        repeat (5) @(negedge clk);

        // hashchecker never answers.
        chk_silent = 1'b1;
        push_upto_a(0);
        start_run_a();
        wait_done_a("chk_timeout");
        chk("chk_timeout_cycle", 160'(cyc), 160'(exp_chk_cyc + 17));
        chk("chk_timeout_flags", 160'({tmo_a, match_a, busy_a}), 160'(3'b100));
        chk("chk_timeout_count", 160'(cnt_a), 160'(0));
        chk_silent = 1'b0;
        repeat (5) @(negedge clk);

        // Abort in MD4_WAIT together with start: abort wins, candidate untouched.
        md4_silent = 1'b1;
        push_upto_a(0);
        start_run_a();
        wait_irdy_a();
        @(negedge clk);
        abort_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        chk("abort_flags", 160'({busy_a, done_a, tmo_a, match_a}), 160'(0));
        chk("abort_cand", pc_a, cand_a(0).chars);
        chk("abort_len", 160'(pl_a), 160'(1));
        abort_a = 1'b0;
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", 160'({busy_a, irdy_a}), 160'(0));
        md4_silent = 1'b0;
        push_upto_a(total_a() - 1);
        start_run_a();
        wait_done_a("restart");
        chk("restart_count", 160'(cnt_a), 160'(total_a()));
        chk("restart_queue_left", 160'(exp_a.size()), 160'(0));

        // Reset in CHK_WAIT while the verdict arrives.
        chk_silent = 1'b1;
        push_upto_a(0);
        start_run_a();
        wait_chk_a();
        @(negedge clk);
        rst_n = 1'b0;
        rr_f  = 1'b1;
        mf_f  = 1'b1;
        @(negedge clk);
        chk("rst_flags", 160'({busy_a, done_a, match_a, tmo_a, irdy_a, chk_a, cnt_a, pl_a}), 160'(0));
        chk("rst_chars", pc_a, 160'(0));
        rst_n = 1'b1;
        rr_f  = 1'b0;
        mf_f  = 1'b0;
        chk_silent = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_after", 160'({busy_a, done_a, cnt_a}), 160'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
